mole_hit_detector: RTL
======================

Name: mole_hit_detector

Overview:
- Player-side front end of the whack-a-mole target.
- Takes the raw hit-sensor contact and the target-lit signal from the target/score block. Synchronises and debounces the sensor, then classifies each press as a hit, a miss, or ignored.
- Emits one-cycle event pulses and the reaction time of each hit.
- Its hit_pulse feeds the scorer's hit input.

Parameters:
- SYNC_STAGES, 2, flops in the sensor synchroniser chain (minimum 2).
- DEBOUNCE_CYCLES, 4, consecutive stable synchronised cycles required before the debounced level changes (minimum 1).
- RT_WIDTH, 8, width of the reaction-time counter and output.

Ports:
- clk  in  1  system clock; every flop is rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- sensor_raw  in  1  raw, bouncy, asynchronous hit-sensor contact; 1 = pressed.
- target_on  in  1  target lit; synchronous to clk.
- hit_pulse  out  1  one-cycle pulse: a valid hit on a lit target.
- miss_pulse  out  1  one-cycle pulse: a press while the target is dark.
- timeout_pulse  out  1  one-cycle pulse: the target went dark without being hit.
- react_valid  out  1  one-cycle pulse, coincident with hit_pulse.
- react_time  out  RT_WIDTH  cycles from target lit to hit; holds its value until the next hit.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - All outputs 0, react_time 0.
  - Synchroniser flops 0, debounced level 0, debounce counter 0.
  - State IDLE, timer 0.
- Synchroniser: sensor_raw passes through SYNC_STAGES flops to give s.
- Debounce:
  - Counter clears whenever s equals the debounced level db. Otherwise it increments.
  - When the counter equals DEBOUNCE_CYCLES-1 and s still differs, db takes s on that edge and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes db.
- Press event: db rises (db=1, previous db=0). Release produces no event.
- Latency: take edge 0 as the first edge that samples sensor_raw=1, with the input held stable after that.
  - The event output is high after edge SYNC_STAGES+DEBOUNCE_CYCLES, for exactly one cycle.
  - With the defaults, that is high after edge 6.
- FSM states: IDLE, ARMED, HIT_HOLD. All transitions are registered.
- IDLE:
  - target_on=1 moves to ARMED and clears the timer to 0.
  - A press with target_on=0 drives miss_pulse.
  - A press in the same cycle that target_on rises is treated as ARMED: hit with react_time 0.
- ARMED:
  - The timer increments each cycle and saturates at 2^RT_WIDTH-1 (no wrap).
  - A press drives hit_pulse and react_valid, latches react_time<=timer, and moves to HIT_HOLD.
  - target_on=0 without a press drives timeout_pulse and moves to IDLE.
  - A press in the same cycle that target_on falls counts as a hit (press wins) and moves to IDLE directly; no timeout.
- HIT_HOLD:
  - Presses are ignored: no pulses.
  - target_on=0 moves to IDLE. It does not produce timeout_pulse.
- Mutual exclusion: at most one of hit_pulse, miss_pulse or timeout_pulse is high in any cycle.
- Reset mid-operation:
  - Any pending debounce count or hold is discarded.
  - If the sensor is held pressed through reset release, db rises after the normal latency and produces one event classified by the state at that time (IDLE: miss).

Decomposition:
- Shared package mole_pkg:
  - state enum (IDLE, ARMED, HIT_HOLD);
  - default constants for SYNC_STAGES, DEBOUNCE_CYCLES, RT_WIDTH.
- Sub-module sensor_debounce holds the synchroniser, debounce counter and rising-edge detect. It outputs press_evt (one cycle) and db_level.
- Top level holds the FSM, timer and output registers.

Test Plan:
- Clean press, target dark: hold sensor_raw=1 with target_on=0 -> miss_pulse high for exactly 1 cycle after edge 6; no other pulse.
- Hit timing: raise target_on, then press so that press_evt arrives 20 cycles after ARMED entry -> hit_pulse and react_valid for 1 cycle, react_time=20. A second press before target_on falls -> no pulse.
- Bounce rejection: toggle sensor_raw 1/0 every 2 cycles for 30 cycles, then hold 1 -> exactly one event, after edge 6 from the final stable sample.
- Timeout and saturation: target_on=1 for 300 cycles, no press, then 0 -> timeout_pulse for 1 cycle. A hit in a 300-cycle window -> react_time=255.
- Simultaneous: press_evt in the same cycle target_on falls -> hit_pulse, no timeout_pulse, state IDLE. Press_evt in the same cycle target_on rises -> hit with react_time=0.
- Reset mid-debounce: drop rst_n while the debounce counter is at 2 -> all outputs 0 immediately. Sensor held through release -> one miss_pulse 6 cycles after the first post-reset edge.

Source files
------------

// File: rtl/mole_pkg.sv
// Shared types and default sizing for the whack-a-mole hit detector.
// Imported by the interface, the debounce front end and the top level.
package mole_pkg;

    localparam int SYNC_STAGES_DEF     = 2;
    localparam int DEBOUNCE_CYCLES_DEF = 4;
    localparam int RT_WIDTH_DEF        = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        HIT_HOLD = 2'd2
    } state_t;

    // Width of a counter that must reach n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mole_hit_detector_if.sv
// Target-lit input and event outputs between the hit detector (master)
// and the target/score block (slave).
interface mole_hit_detector_if
    import mole_pkg::*;
#(
    parameter int RT_WIDTH = RT_WIDTH_DEF
);

    logic                target_on;
    logic                hit_pulse;
    logic                miss_pulse;
    logic                timeout_pulse;
    logic                react_valid;
    logic [RT_WIDTH-1:0] react_time;

    modport master (
        input  target_on,
        output hit_pulse,
        output miss_pulse,
        output timeout_pulse,
        output react_valid,
        output react_time
    );

    modport slave (
        output target_on,
        input  hit_pulse,
        input  miss_pulse,
        input  timeout_pulse,
        input  react_valid,
        input  react_time
    );

endinterface

// File: rtl/mole_hit_detector_sensor_debounce.sv
// Sensor front end: synchroniser chain, stability debouncer and a
// one-cycle press event on the rising edge of the debounced level.
module sensor_debounce
    import mole_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sensor_raw,
    output logic press_evt,
    output logic db_level
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q;
    logic                   db_q;
    logic                   db_prev_q;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sensor_raw};
        end
    end

    // The level only moves after s has disagreed with it for DEBOUNCE_CYCLES
    // consecutive cycles; any agreement in between restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            db_q      <= 1'b0;
            db_prev_q <= 1'b0;
        end else begin
            db_prev_q <= db_q;
            if (s == db_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                db_q  <= s;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign press_evt = db_q & ~db_prev_q;
    assign db_level  = db_q;

endmodule

// File: rtl/mole_hit_detector.sv
// Hit classifier: turns debounced presses into hit/miss/timeout pulses and
// measures reaction time from target lit to hit.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   IDLE     | target dark; a press is a miss
//   ARMED    | target lit, timer running; a press is a hit
//   HIT_HOLD | target already hit; presses ignored until it goes dark
module mole_hit_detector
    import mole_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int RT_WIDTH        = RT_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sensor_raw,
    mole_hit_detector_if.master   evt
);

    localparam logic [RT_WIDTH-1:0] TIMER_MAX = '1;

    logic                press_evt;
    state_t              state_q, state_d;
    logic [RT_WIDTH-1:0] timer_q, timer_d;
    logic [RT_WIDTH-1:0] react_q, react_d;
    logic                hit_q, hit_d;
    logic                miss_q, miss_d;
    logic                timeout_q, timeout_d;

    sensor_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk        (clk),
        .rst_n      (rst_n),
        .sensor_raw (sensor_raw),
        .press_evt  (press_evt),
        .db_level   ()
    );

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        react_d   = react_q;
        hit_d     = 1'b0;
        miss_d    = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (evt.target_on) begin
                    timer_d = '0;
                    // A press landing on the rising edge of target_on is a zero-time hit.
                    if (press_evt) begin
                        hit_d   = 1'b1;
                        react_d = '0;
                        state_d = HIT_HOLD;
                    end else begin
                        state_d = ARMED;
                    end
                end else if (press_evt) begin
                    miss_d = 1'b1;
                end
            end
            ARMED: begin
                timer_d = (timer_q == TIMER_MAX) ? timer_q : timer_q + 1'b1;
                if (press_evt) begin
                    hit_d   = 1'b1;
                    react_d = timer_q;
                    state_d = evt.target_on ? HIT_HOLD : IDLE;
                end else if (!evt.target_on) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            HIT_HOLD: begin
                if (!evt.target_on) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            react_q   <= '0;
            hit_q     <= 1'b0;
            miss_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            react_q   <= react_d;
            hit_q     <= hit_d;
            miss_q    <= miss_d;
            timeout_q <= timeout_d;
        end
    end

    assign evt.hit_pulse     = hit_q;
    assign evt.react_valid   = hit_q;
    assign evt.miss_pulse    = miss_q;
    assign evt.timeout_pulse = timeout_q;
    assign evt.react_time    = react_q;

endmodule
